// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and op-decode helpers for the iterative MDU.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(mdu_op_e op);
        return op[2] & op[1];
    endfunction

    // MUL yields the low half, which is sign-agnostic, so it is treated as unsigned
    function automatic logic is_signed_a(mdu_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(mdu_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_mul_hi(mdu_op_e op);
        return !op[2] && (op[1:0] != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_if
// Description : Request/response bundle between the execute stage and the MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, a, b,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/mdu_cneg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_cneg
// Description : Conditional two's-complement negate of a WIDTH-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_cneg #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign o_data = i_neg ? (~i_data + c_ONE) : i_data;
endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative RV32M multiply/divide unit, UNROLL bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    import mdu_pkg::*;

    localparam int                 c_LAT   = XLEN / UNROLL;
    localparam int                 c_CNT_W = (c_LAT > 1) ? $clog2(c_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]    c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e         r_state, w_state_next;
    mdu_op_e            r_op, w_op_in;
    logic               r_neg;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_opb;
    logic [XLEN-1:0]    r_result;

    logic               w_sign_a, w_sign_b, w_neg_in;
    logic               w_b_zero, w_ovf, w_fast, w_accept;
    logic [XLEN-1:0]    w_mag_a, w_mag_b, w_fast_result, w_final;
    logic [2*XLEN-1:0]  w_acc_next, w_fin_src, w_fin_neg;
    logic [XLEN:0]      w_rem_t, w_sum;
    logic [XLEN-1:0]    w_lo_t;

    // ---------------- request decode ----------------
    assign w_op_in  = mdu_op_e'(bus.op);
    assign w_sign_a = is_signed_a(w_op_in) & bus.a[XLEN-1];
    assign w_sign_b = is_signed_b(w_op_in) & bus.b[XLEN-1];
    // Remainder follows the dividend; everything else follows the sign product
    assign w_neg_in = is_rem(w_op_in) ? w_sign_a : (w_sign_a ^ w_sign_b);
    assign w_b_zero = (bus.b == '0);
    assign w_ovf    = is_signed_a(w_op_in) && (bus.a == c_MIN) && (bus.b == '1);
    assign w_fast   = is_div(w_op_in) && (w_b_zero || w_ovf);
    assign w_accept = bus.start && !bus.flush && (r_state != BUSY);

    always_comb begin
        w_fast_result = '0;
        if (is_rem(w_op_in)) begin
            w_fast_result = w_b_zero ? bus.a : '0;
        end else begin
            w_fast_result = w_b_zero ? '1 : bus.a;
        end
    end

    mdu_cneg #(.WIDTH(XLEN)) u_mag_a (
        .i_neg  (w_sign_a),
        .i_data (bus.a),
        .o_data (w_mag_a)
    );

    mdu_cneg #(.WIDTH(XLEN)) u_mag_b (
        .i_neg  (w_sign_b),
        .i_data (bus.b),
        .o_data (w_mag_b)
    );

    // ---------------- iteration datapath ----------------
    // Multiply shifts the accumulator right (multiplier in the low half);
    // divide shifts left with the partial remainder in the high half.
    always_comb begin
        w_acc_next = r_acc;
        w_rem_t    = '0;
        w_sum      = '0;
        w_lo_t     = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div(r_op)) begin
                w_rem_t = {w_acc_next[2*XLEN-1:XLEN], w_acc_next[XLEN-1]};
                w_lo_t  = {w_acc_next[XLEN-2:0], 1'b0};
                if (w_rem_t >= {1'b0, r_opb}) begin
                    w_rem_t   = w_rem_t - {1'b0, r_opb};
                    w_lo_t[0] = 1'b1;
                end
                w_acc_next = {w_rem_t[XLEN-1:0], w_lo_t};
            end else begin
                w_sum      = {1'b0, w_acc_next[2*XLEN-1:XLEN]}
                           + (w_acc_next[0] ? {1'b0, r_opb} : '0);
                w_acc_next = {w_sum, w_acc_next[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        w_fin_src = w_acc_next;
        if (is_div(r_op)) begin
            w_fin_src = {{XLEN{1'b0}},
                         is_rem(r_op) ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0]};
        end
    end

    mdu_cneg #(.WIDTH(2*XLEN)) u_fix_sign (
        .i_neg  (r_neg),
        .i_data (w_fin_src),
        .o_data (w_fin_neg)
    );

    assign w_final = is_mul_hi(r_op) ? w_fin_neg[2*XLEN-1:XLEN] : w_fin_neg[XLEN-1:0];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.busy     = (r_state == BUSY);
        bus.done     = (r_state == DONE);
        if (bus.flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        w_state_next = w_fast ? DONE : BUSY;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        w_state_next = DONE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= w_op_in;
            r_neg <= w_neg_in;
            r_cnt <= c_LAST;
            if (is_div(w_op_in)) begin
                r_acc <= {{XLEN{1'b0}}, w_mag_a};
                r_opb <= w_mag_b;
            end else begin
                r_acc <= {{XLEN{1'b0}}, w_mag_b};
                r_opb <= w_mag_a;
            end
            if (w_fast) begin
                r_result <= w_fast_result;
            end
        end else if ((r_state == BUSY) && !bus.flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - c_ONE;
            if (r_cnt == '0) begin
                r_result <= w_final;
            end
        end
    end

    assign bus.result = r_result;

endmodule
`default_nettype wire
